// File: rtl/adam_axil_sram_slv.sv
// AXI-Lite slave backed by a DEPTH-word register array, with independent write/read engines and a pause handshake.
// Define ADAM_AXIL_SRAM_SLV_PROT_EN to reject unprivileged (prot[0]=0) accesses with SLVERR.
module adam_axil_sram_slv #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pause_req,
  output logic                  pause_ack,
  input  logic [ADDR_WIDTH-1:0] aw_addr,
  input  logic [2:0]            aw_prot,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [STRB_WIDTH-1:0] w_strb,
  input  logic                  w_valid,
  output logic                  w_ready,
  output logic [1:0]            b_resp,
  output logic                  b_valid,
  input  logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic [2:0]            ar_prot,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [1:0]            r_resp,
  output logic                  r_valid,
  input  logic                  r_ready
);

  localparam int OFFS = $clog2(STRB_WIDTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t wstate, wstate_nx;
  rstate_t rstate, rstate_nx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  pause_q;
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic                  aw_hs, w_hs, ar_hs, wr_fire;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  wr_ok, rd_ok;

  function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
    return (a - BASE_ADDR) >> OFFS;
  endfunction

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a >= BASE_ADDR) && (word_index(a) < DEPTH_A);
  endfunction

  // A half already captured takes priority over the live bus so AW and W can arrive in any order.
  assign wr_addr = aw_held ? aw_addr_q : aw_addr;
  assign wr_data = w_held ? w_data_q : w_data;
  assign wr_strb = w_held ? w_strb_q : w_strb;
  assign wr_idx  = IDX_W'(word_index(wr_addr));
  assign rd_idx  = IDX_W'(word_index(ar_addr));

`ifdef ADAM_AXIL_SRAM_SLV_PROT_EN
  logic aw_priv_q;
  logic wr_priv;
  assign wr_priv = aw_held ? aw_priv_q : aw_prot[0];
  assign wr_ok   = addr_ok(wr_addr) && wr_priv;
  assign rd_ok   = addr_ok(ar_addr) && ar_prot[0];
`else
  logic unused_prot;
  assign unused_prot = ^{aw_prot, ar_prot};
  assign wr_ok = addr_ok(wr_addr);
  assign rd_ok = addr_ok(ar_addr);
`endif

  assign b_valid   = (wstate == W_RESP);
  assign r_valid   = (rstate == R_DATA);
  assign pause_ack = pause_q && (wstate == W_IDLE) && (rstate == R_IDLE) && !aw_held && !w_held;

  always_comb begin
    wstate_nx = wstate;
    rstate_nx = rstate;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    ar_ready  = 1'b0;
    wr_fire   = 1'b0;
    // While pausing, only the missing half of a partly captured write is still accepted.
    case (wstate)
      W_IDLE: begin
        aw_ready = !aw_held && (!pause_q || w_held);
        w_ready  = !w_held && (!pause_q || aw_held);
        if ((aw_held || (aw_valid && aw_ready)) && (w_held || (w_valid && w_ready))) begin
          wr_fire   = 1'b1;
          wstate_nx = W_RESP;
        end
      end
      W_RESP: if (b_ready) wstate_nx = W_IDLE;
    endcase
    case (rstate)
      R_IDLE: begin
        ar_ready = !pause_q;
        if (ar_valid && ar_ready) rstate_nx = R_DATA;
      end
      R_DATA: if (r_ready) rstate_nx = R_IDLE;
    endcase
    aw_hs = aw_valid && aw_ready;
    w_hs  = w_valid && w_ready;
    ar_hs = ar_valid && ar_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate    <= W_IDLE;
      rstate    <= R_IDLE;
      pause_q   <= 1'b1;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_resp    <= RESP_OKAY;
      r_resp    <= RESP_OKAY;
      r_data    <= '0;
`ifdef ADAM_AXIL_SRAM_SLV_PROT_EN
      aw_priv_q <= 1'b0;
`endif
    end else begin
      wstate  <= wstate_nx;
      rstate  <= rstate_nx;
      pause_q <= pause_req;
      if (aw_hs) begin
        aw_addr_q <= aw_addr;
`ifdef ADAM_AXIL_SRAM_SLV_PROT_EN
        aw_priv_q <= aw_prot[0];
`endif
      end
      if (w_hs) begin
        w_data_q <= w_data;
        w_strb_q <= w_strb;
      end
      if (wr_fire) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        b_resp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) aw_held <= 1'b1;
        if (w_hs)  w_held  <= 1'b1;
      end
      if (ar_hs) begin
        r_resp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        r_data <= rd_ok ? mem[rd_idx] : '0;
      end
    end
  end

  // Array is deliberately not reset; it only changes on a completing in-range write.
  always_ff @(posedge clk) begin
    if (wr_fire && wr_ok) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wr_strb[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

endmodule
